// File: rtl/riscv_trace_monitor.sv
// ----------------------------------------------------------------------------
// riscv_trace_monitor
//   Watches the core debug port (debug_pc/debug_instr) every clock, records
//   each new PC/instruction pair into a circular trace buffer and decides the
//   end of a test in hardware: the halt instruction ends the run as PASS, and a
//   RUN-cycle timeout ends it as FAIL. The trace is drained through a
//   valid/ready read port in any state.
//
//   Optional feature macro: TRACE_TIMESTAMP_EN
//     defined     -> every entry also stores the RUN cycle count at capture;
//                    rd_cycle shows the head stamp (0 when empty).
//     not defined -> no stamp storage and no rd_cycle port.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                1-cycle pulse: begins/restarts a run (ignored in RUN)
//   debug_pc/debug_instr core retire stream, sampled every clock
//   rd_valid/rd_ready    trace head handshake; pop on rd_valid && rd_ready
//   rd_pc/rd_instr       head entry contents
//   rd_cycle             head entry cycle stamp (TRACE_TIMESTAMP_EN only)
//   count                buffer occupancy 0..DEPTH
//   overflow             sticky: a capture was dropped because buffer full
//   done/pass            run finished / run finished by halt instruction
//   cycles               RUN cycles elapsed, saturating
// ----------------------------------------------------------------------------
module riscv_trace_monitor #(
  parameter int unsigned DEPTH          = 16,
  parameter logic [31:0] HALT_INSTR     = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [31:0]                debug_pc,
  input  logic [31:0]                debug_instr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [31:0]                rd_pc,
  output logic [31:0]                rd_instr,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]                rd_cycle,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       done,
  output logic                       pass,
  output logic [31:0]                cycles
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // Last RUN cycle value before the timeout fires; only used when enabled.
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic [31:0]       r_cycles;
  logic [31:0]       r_last_pc;
  logic              r_last_vld;

  logic [31:0]       r_mem_pc    [DEPTH];
  logic [31:0]       r_mem_instr [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]       r_mem_cycle [DEPTH];
`endif

  logic w_run;
  logic w_halt;
  logic w_timeout;
  logic w_cap_evt;
  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_drop;
  logic w_restart;

  assign w_run     = (r_state == S_RUN);
  assign w_halt    = w_run && (debug_instr == HALT_INSTR);
  assign w_timeout = w_run && TO_EN && (r_cycles == TO_LAST);
  // A new entry is due when nothing has been captured yet this run or the PC moved.
  assign w_cap_evt = w_run && (!r_last_vld || (debug_pc != r_last_pc));
  assign w_pop     = rd_valid && rd_ready;
  assign w_full    = (r_count == FULL_CNT);
  // A simultaneous pop frees the slot, so a full buffer can still accept.
  assign w_wr      = w_cap_evt && (!w_full || w_pop);
  assign w_drop    = w_cap_evt && w_full && !w_pop;
  assign w_restart = start && (r_state != S_RUN);

  // Next-state logic for the run controller; halt takes priority over timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
        else       w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_halt)         w_state_nxt = S_PASS;
        else if (w_timeout) w_state_nxt = S_FAIL;
        else                w_state_nxt = S_RUN;
      end
      S_PASS, S_FAIL: begin
        if (start) w_state_nxt = S_RUN;
        else       w_state_nxt = r_state;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Buffer pointers, occupancy, sticky overflow, cycle counter and last-PC tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cycles   <= 32'd0;
      r_last_pc  <= 32'd0;
      r_last_vld <= 1'b0;
    end else if (w_restart) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cycles   <= 32'd0;
      r_last_vld <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      if (w_run && (r_cycles != 32'hFFFF_FFFF)) r_cycles <= r_cycles + 32'd1;
      if (w_cap_evt) begin
        r_last_pc  <= debug_pc;
        r_last_vld <= 1'b1;
      end
    end
  end

  // Trace storage write port; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (w_wr && !w_restart) begin
      r_mem_pc[r_wptr]    <= debug_pc;
      r_mem_instr[r_wptr] <= debug_instr;
`ifdef TRACE_TIMESTAMP_EN
      r_mem_cycle[r_wptr] <= r_cycles;
`endif
    end
  end

  assign rd_valid = (r_count != '0);
  assign rd_pc    = rd_valid ? r_mem_pc[r_rptr]    : 32'd0;
  assign rd_instr = rd_valid ? r_mem_instr[r_rptr] : 32'd0;
`ifdef TRACE_TIMESTAMP_EN
  assign rd_cycle = rd_valid ? r_mem_cycle[r_rptr] : 32'd0;
`endif
  assign count    = r_count;
  assign overflow = r_overflow;
  assign done     = (r_state == S_PASS) || (r_state == S_FAIL);
  assign pass     = (r_state == S_PASS);
  assign cycles   = r_cycles;

endmodule

// File: tb/tb_riscv_trace_monitor.sv
// ----------------------------------------------------------------------------
// tb_riscv_trace_monitor
//   Directed scenarios plus a randomized phase, all compared every cycle with
//   a queue-based reference model of the trace monitor.
// ----------------------------------------------------------------------------
module tb_riscv_trace_monitor;

  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'h0000_0013;
  localparam int          TO    = 100;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0050_0093;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rd_ready = 1'b0;
  logic [31:0]   debug_pc = 32'd0;
  logic [31:0]   debug_instr = 32'd0;
  logic          rd_valid;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_instr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          done;
  logic          pass;
  logic [31:0]   cycles;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]   rd_cycle;
`endif

  riscv_trace_monitor #(
    .DEPTH(DEPTH), .HALT_INSTR(HALT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .debug_pc(debug_pc), .debug_instr(debug_instr),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr),
`ifdef TRACE_TIMESTAMP_EN
    .rd_cycle(rd_cycle),
`endif
    .count(count), .overflow(overflow), .done(done), .pass(pass),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of entries plus a handful of run flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] cyc;
  } ent_t;

  ent_t        mq[$];
  bit          m_run, m_done, m_pass, m_ovf, m_lv;
  logic [31:0] m_last, m_cyc;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_stamp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_run = 0; m_done = 0; m_pass = 0; m_ovf = 0; m_lv = 0;
    m_last = 32'd0; m_cyc = 32'd0;
  endtask

  // Advance the model by one clock edge with the inputs currently driven.
  task automatic m_edge();
    bit   pop, cap;
    ent_t e;
    pop = (mq.size() != 0) && rd_ready;
    if (start && !m_run) begin
      mq.delete();
      m_ovf = 0; m_done = 0; m_pass = 0; m_cyc = 32'd0; m_lv = 0; m_run = 1;
    end else if (m_run) begin
      cap = !m_lv || (debug_pc != m_last);
      if (pop) void'(mq.pop_front());
      if (cap) begin
        e.pc = debug_pc; e.ins = debug_instr; e.cyc = m_cyc;
        if (mq.size() < DEPTH) mq.push_back(e);
        else                   m_ovf = 1;
        m_last = debug_pc; m_lv = 1;
      end
      if (debug_instr == HALT) begin
        m_run = 0; m_done = 1; m_pass = 1;
      end else if (m_cyc == 32'(TO - 1)) begin
        m_run = 0; m_done = 1;
      end
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
    end else if (pop) begin
      void'(mq.pop_front());
    end
  endtask

  task automatic compare_all();
    check_eq("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
    check_eq("count", 64'(count), 64'(mq.size()));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("done", 64'(done), 64'(m_done));
    check_eq("pass", 64'(pass), 64'(m_pass));
    check_eq("cycles", 64'(cycles), 64'(m_cyc));
    if (mq.size() != 0) begin
      check_eq("rd_pc", 64'(rd_pc), 64'(mq[0].pc));
      check_eq("rd_instr", 64'(rd_instr), 64'(mq[0].ins));
`ifdef TRACE_TIMESTAMP_EN
      check_eq("rd_cycle", 64'(rd_cycle), 64'(mq[0].cyc));
`endif
    end
`ifdef TRACE_TIMESTAMP_EN
    else check_eq("rd_cycle_empty", 64'(rd_cycle), 64'd0);
`endif
  endtask

  task automatic step(input logic s, input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
    start = s; debug_pc = pc; debug_instr = ins; rd_ready = rdy;
    m_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Read out everything left in the buffer while the run is finished.
  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'hDEAD_0000, NOP, 1'b1);
    check_eq("drained", 64'(count), 64'd0);
  endtask

  initial begin
    m_reset();
    // 1: reset held 5 cycles
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    compare_all();
    check_eq("reset_valid", 64'(rd_valid), 64'd0);
    check_eq("reset_cycles", 64'(cycles), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: three PCs then halt -> 4 entries, pass, cycles=4
    step(1'b1, 32'd0, NOP, 1'b0);
    step(1'b0, 32'h0, NOP, 1'b0);
    step(1'b0, 32'h4, NOP, 1'b0);
    step(1'b0, 32'h8, NOP, 1'b0);
    step(1'b0, 32'hC, HALT, 1'b0);
    check_eq("t2_count", 64'(count), 64'd4);
    check_eq("t2_pass", 64'(pass), 64'd1);
    check_eq("t2_cycles", 64'(cycles), 64'd4);
    check_eq("t2_head", 64'(rd_pc), 64'h0);
    drain();

    // 3: held PC produces one entry only
    step(1'b1, 32'd0, NOP, 1'b0);
    repeat (3) step(1'b0, 32'h10, NOP, 1'b0);
    step(1'b0, 32'h14, NOP, 1'b0);
    check_eq("t3_count", 64'(count), 64'd2);
    step(1'b0, 32'h14, HALT, 1'b0);
    check_eq("t3_count_halt", 64'(count), 64'd2);
    drain();

    // 4: six distinct PCs with no reads -> full and overflow
    step(1'b1, 32'd0, NOP, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h100 + 32'(i * 4), NOP, 1'b0);
    check_eq("t4_count", 64'(count), 64'(DEPTH));
    check_eq("t4_overflow", 64'(overflow), 64'd1);
    check_eq("t4_head", 64'(rd_pc), 64'h100);
    step(1'b0, 32'h100, HALT, 1'b0);
    drain();

    // 6: full buffer, pop and capture together -> no overflow, count stays
    step(1'b1, 32'd0, NOP, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h200 + 32'(i * 4), NOP, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h300 + 32'(i * 4), NOP, 1'b1);
      check_eq("t6_count", 64'(count), 64'(DEPTH));
      check_eq("t6_overflow", 64'(overflow), 64'd0);
    end
    step(1'b0, 32'h400, HALT, 1'b1);
`ifdef TRACE_TIMESTAMP_EN
    last_stamp = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 0) check_eq("t6_stamp_up", 64'(rd_cycle > last_stamp), 64'd1);
      last_stamp = rd_cycle;
      step(1'b0, 32'h0, NOP, 1'b1);
    end
`endif
    drain();

    // 5: timeout -> done exactly TO cycles after start, pass=0, cycles=TO
    step(1'b1, 32'd0, NOP, 1'b0);
    for (int i = 1; i < TO; i++) step(1'b0, 32'(i * 4), NOP, 1'($urandom_range(0, 1)));
    check_eq("t5_not_yet", 64'(done), 64'd0);
    step(1'b0, 32'(TO * 4), NOP, 1'b0);
    check_eq("t5_done", 64'(done), 64'd1);
    check_eq("t5_pass", 64'(pass), 64'd0);
    check_eq("t5_cycles", 64'(cycles), 64'(TO));
    repeat (3) step(1'b0, 32'h5000, NOP, 1'b0);
    check_eq("t5_frozen", 64'(cycles), 64'(TO));
    drain();

    // halt on the timeout cycle -> pass wins
    step(1'b1, 32'd0, NOP, 1'b0);
    for (int i = 1; i < TO; i++) step(1'b0, 32'(i * 4), NOP, 1'b1);
    step(1'b0, 32'h7000, HALT, 1'b1);
    check_eq("tie_pass", 64'(pass), 64'd1);
    drain();

    // mid-run asynchronous reset
    step(1'b1, 32'd0, NOP, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h40 + 32'(i * 4), NOP, 1'b0);
    rst_n = 1'b0;
    m_reset();
    #1;
    compare_all();
    check_eq("async_count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h44, NOP, 1'b0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc, ins;
      pc  = ($urandom_range(0, 1) == 0) ? debug_pc : 32'($urandom_range(0, 7) * 4);
      ins = ($urandom_range(0, 149) == 0) ? HALT : $urandom;
      if (ins == HALT && $urandom_range(0, 149) != 0) ins = NOP;
      step(1'($urandom_range(0, 24) == 0), pc, ins, 1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
